// File: rtl/spi_cmd_sched.sv
// Round-robin scheduler sharing one SPI frame engine; grant->o_tx_vld next cycle, ack one cycle after done/timeout.
// Engine backpressure holds o_tx_vld/o_tx_data stable; requests wait until IDLE (no queueing beyond i_req levels).
module spi_cmd_sched #(
  parameter int REQ_NUM = 3,
  parameter int DATA_W  = 24,
  parameter int GAP_CYC = 10,
  parameter int TO_CYC  = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [REQ_NUM-1:0]        i_req,
  input  logic [REQ_NUM*DATA_W-1:0] i_req_data,
  output logic [REQ_NUM-1:0]        o_ack,
  output logic [DATA_W-1:0]         o_rsp_data,
  output logic                      o_rsp_err,
  output logic                      o_tx_vld,
  output logic [DATA_W-1:0]         o_tx_data,
  input  logic                      i_tx_rdy,
  input  logic                      i_tx_done,
  input  logic [DATA_W-1:0]         i_rx_data,
  output logic                      o_busy
);

  localparam int IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int TO_W  = (TO_CYC > 1) ? $clog2(TO_CYC + 1) : 1;
  localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REQ_NUM - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_BUSY, ST_RESP, ST_GAP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [REQ_NUM-1:0] ack_q, ack_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic               tx_vld_q, tx_vld_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic               busy_q;

  logic [DATA_W-1:0]  req_word [REQ_NUM];
  logic               arb_hit;
  logic [IDX_W-1:0]   arb_idx;
  logic [IDX_W-1:0]   arb_cand;

  for (genvar g = 0; g < REQ_NUM; g++) begin : g_word
    assign req_word[g] = i_req_data[g*DATA_W +: DATA_W];
  end

  // Scan ptr+1, ptr+2, ... with explicit wrap so non-power-of-2 REQ_NUM stays in range.
  always_comb begin
    arb_hit  = 1'b0;
    arb_idx  = '0;
    arb_cand = ptr_q;
    for (int i = 0; i < REQ_NUM; i++) begin
      arb_cand = (arb_cand == LAST_IDX) ? '0 : arb_cand + 1'b1;
      if (!arb_hit && i_req[arb_cand]) begin
        arb_hit = 1'b1;
        arb_idx = arb_cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    to_cnt_d   = to_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    ack_d      = '0;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    tx_vld_d   = tx_vld_q;
    tx_data_d  = tx_data_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_hit) begin
          grant_d   = arb_idx;
          tx_data_d = req_word[arb_idx];
          tx_vld_d  = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (tx_vld_q && i_tx_rdy) begin
          tx_vld_d = 1'b0;
          to_cnt_d = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        to_cnt_d = to_cnt_q + 1'b1;
        // Done takes priority over a timeout landing in the same cycle.
        if (i_tx_done) begin
          rsp_data_d     = i_rx_data;
          rsp_err_d      = 1'b0;
          ack_d[grant_q] = 1'b1;
          state_d        = ST_RESP;
        end else if (to_cnt_q == TO_LAST) begin
          rsp_data_d     = '0;
          rsp_err_d      = 1'b1;
          ack_d[grant_q] = 1'b1;
          state_d        = ST_RESP;
        end
      end
      ST_RESP: begin
        ptr_d     = grant_q;
        gap_cnt_d = '0;
        state_d   = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
        else                       gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= LAST_IDX;
      grant_q    <= '0;
      to_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      ack_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      tx_vld_q   <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      to_cnt_q   <= to_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      ack_q      <= ack_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      tx_vld_q   <= tx_vld_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign o_ack      = ack_q;
  assign o_rsp_data = rsp_data_q;
  assign o_rsp_err  = rsp_err_q;
  assign o_tx_vld   = tx_vld_q;
  assign o_tx_data  = tx_data_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_spi_cmd_sched.sv
// Bench for spi_cmd_sched: engine model, scoreboard queues of expected commands/responses/ack times.
`timescale 1ns/1ps
module tb_spi_cmd_sched;

  localparam int REQ_NUM = 3;
  localparam int DATA_W  = 24;

  logic                      i_clk;
  logic                      i_rst_n;
  logic [REQ_NUM-1:0]        i_req;
  logic [REQ_NUM*DATA_W-1:0] i_req_data;
  logic [REQ_NUM-1:0]        o_ack;
  logic [DATA_W-1:0]         o_rsp_data;
  logic                      o_rsp_err;
  logic                      o_tx_vld;
  logic [DATA_W-1:0]         o_tx_data;
  logic                      i_tx_rdy;
  logic                      i_tx_done;
  logic [DATA_W-1:0]         i_rx_data;
  logic                      o_busy;

  spi_cmd_sched #(.REQ_NUM(3), .DATA_W(24), .GAP_CYC(10), .TO_CYC(255)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_req      (i_req),
    .i_req_data (i_req_data),
    .o_ack      (o_ack),
    .o_rsp_data (o_rsp_data),
    .o_rsp_err  (o_rsp_err),
    .o_tx_vld   (o_tx_vld),
    .o_tx_data  (o_tx_data),
    .i_tx_rdy   (i_tx_rdy),
    .i_tx_done  (i_tx_done),
    .i_rx_data  (i_rx_data),
    .o_busy     (o_busy)
  );

  typedef struct packed {
    logic [2:0]  ack;
    logic [23:0] dat;
    logic        err;
  } exp_t;

  exp_t        expq[$];
  int          edgeq[$];
  logic [23:0] txq[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Engine behaviour knobs, set by the stimulus process.
  int          rdy_hold   = 0;
  bit          done_en    = 1'b1;
  int          done_dly   = 24;
  int          late_dly   = 0;
  int          exp_lat    = 24;
  logic [23:0] rx_val     = '0;
  bit          chk_period = 1'b0;
  int          prev_ack   = 0;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic fail(input string nm, input logic [31:0] act);
    n_chk++;
    n_err++;
    $display("FAIL %s: got 0x%0h with nothing expected (cycle %0d)", nm, act, cyc);
  endtask

  task automatic set_word(input int k, input logic [23:0] w);
    i_req_data[k*DATA_W +: DATA_W] = w;
  endtask

  task automatic push_exp(input logic [2:0] a, input logic [23:0] d, input logic e);
    exp_t x;
    x.ack = a;
    x.dat = d;
    x.err = e;
    expq.push_back(x);
  endtask

  task automatic wait_ack(input int budget);
    int b = 0;
    do begin
      @(negedge i_clk);
      b++;
    end while (o_ack == '0 && b < budget);
    chk("ack_seen", {31'd0, (o_ack != '0)}, 32'd1);
  endtask

  // SPI engine model: stalls rdy for rdy_hold cycles, pulses done in BUSY cycle done_dly.
  initial begin : engine
    int          bcnt;
    int          stall;
    logic [23:0] held;
    bcnt = 0; stall = 0; held = '0;
    i_tx_rdy = 1'b0; i_tx_done = 1'b0; i_rx_data = '0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        bcnt  = 0;
        stall = 0;
        edgeq.delete();
      end else begin
        if (bcnt > 0) bcnt++;
        if (o_tx_vld && !i_tx_rdy) begin
          if (stall == 0) held = o_tx_data;
          else chk("tx_hold", {8'd0, o_tx_data}, {8'd0, held});
          stall++;
        end
        if (o_tx_vld && i_tx_rdy) begin
          if (txq.size() == 0) fail("tx_unexpected", {8'd0, o_tx_data});
          else chk("tx_data", {8'd0, o_tx_data}, {8'd0, txq.pop_front()});
          if (rdy_hold > 0) chk("tx_stall_len", stall, rdy_hold);
          stall = 0;
          bcnt  = 1;
          edgeq.push_back(cyc + 1 + exp_lat);
        end
      end
      @(posedge i_clk);
      #1;
      i_tx_rdy  = (stall >= rdy_hold);
      i_tx_done = (bcnt > 0) && ((done_en && bcnt == done_dly) || (late_dly > 0 && bcnt == late_dly));
      i_rx_data = i_tx_done ? rx_val : 24'h0;
    end
  end

  // Monitor: every ack is matched against the next expected response and its expected edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_ack != '0) begin
        if (expq.size() == 0) begin
          fail("ack_unexpected", {29'd0, o_ack});
        end else begin
          e = expq.pop_front();
          chk("ack_who", {29'd0, o_ack}, {29'd0, e.ack});
          chk("rsp_data", {8'd0, o_rsp_data}, {8'd0, e.dat});
          chk("rsp_err", {31'd0, o_rsp_err}, {31'd0, e.err});
        end
        if (edgeq.size() == 0) fail("ack_time_unexpected", cyc);
        else chk("ack_time", cyc, edgeq.pop_front());
        if (chk_period && prev_ack != 0) chk("ack_period", cyc - prev_ack, 37);
        prev_ack = cyc;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  logic [2:0]  rr_ack [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [23:0] rr_cmd [6] = '{24'h111111, 24'h222222, 24'h333333, 24'h111111, 24'h222222, 24'h333333};

  initial begin : stim
    int busy_n;
    i_rst_n = 1'b0; i_req = '0; i_req_data = '0;
    repeat (2) @(negedge i_clk);
    chk("rst_ack",      {29'd0, o_ack}, 0);
    chk("rst_rsp_data", {8'd0, o_rsp_data}, 0);
    chk("rst_rsp_err",  {31'd0, o_rsp_err}, 0);
    chk("rst_tx_vld",   {31'd0, o_tx_vld}, 0);
    chk("rst_tx_data",  {8'd0, o_tx_data}, 0);
    chk("rst_busy",     {31'd0, o_busy}, 0);
    @(posedge i_clk); #1 i_rst_n = 1'b1;

    // Single request from requester 1.
    rdy_hold = 0; done_en = 1'b1; done_dly = 24; exp_lat = 24; rx_val = 24'h00A5C3;
    txq.push_back(24'h8455B1);
    push_exp(3'b010, 24'h00A5C3, 1'b0);
    @(posedge i_clk); #1;
    set_word(1, 24'h8455B1);
    i_req = 3'b010;
    @(negedge i_clk);
    chk("vld_same_cycle", {31'd0, o_tx_vld}, 0);
    @(negedge i_clk);
    chk("vld_next_cycle", {31'd0, o_tx_vld}, 1);
    wait_ack(100);
    @(posedge i_clk); #1 i_req = '0;
    busy_n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      if (o_busy) busy_n++;
    end
    chk("gap_busy_cycles", busy_n, 10);
    @(negedge i_clk);
    chk("idle_after_gap", {31'd0, o_busy}, 0);
    chk("rsp_hold", {8'd0, o_rsp_data}, 24'h00A5C3);

    // Round robin with all three requesting; reset puts the pointer back at REQ_NUM-1.
    @(posedge i_clk); #1 i_rst_n = 1'b0;
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    rx_val = 24'h5A5A5A; prev_ack = 0; chk_period = 1'b1;
    set_word(0, 24'h111111); set_word(1, 24'h222222); set_word(2, 24'h333333);
    for (int f = 0; f < 6; f++) begin
      txq.push_back(rr_cmd[f]);
      push_exp(rr_ack[f], 24'h5A5A5A, 1'b0);
    end
    i_req = 3'b111;
    for (int f = 0; f < 6; f++) wait_ack(100);
    @(posedge i_clk); #1 i_req = '0;
    chk_period = 1'b0;
    repeat (15) @(negedge i_clk);

    // Backpressure: rdy low for 7 cycles, command changes underneath after grant.
    rdy_hold = 7; done_dly = 5; exp_lat = 5; rx_val = 24'h123456;
    set_word(0, 24'hABCDEF);
    txq.push_back(24'hABCDEF);
    push_exp(3'b001, 24'h123456, 1'b0);
    @(posedge i_clk); #1 i_req = 3'b001;
    for (int b = 0; b < 20 && !o_tx_vld; b++) @(negedge i_clk);
    chk("bp_vld_seen", {31'd0, o_tx_vld}, 1);
    @(posedge i_clk); #1 set_word(0, 24'h999999);
    wait_ack(100);
    @(posedge i_clk); #1 i_req = '0;
    rdy_hold = 0;
    repeat (15) @(negedge i_clk);

    // Timeout with a late done landing in GAP.
    done_en = 1'b0; late_dly = 260; exp_lat = 255; rx_val = 24'hDEAD01;
    set_word(2, 24'h0F0F0F);
    txq.push_back(24'h0F0F0F);
    push_exp(3'b100, 24'h000000, 1'b1);
    @(posedge i_clk); #1 i_req = 3'b100;
    wait_ack(400);
    @(posedge i_clk); #1 i_req = '0;
    repeat (20) @(negedge i_clk);
    chk("to_err_hold", {31'd0, o_rsp_err}, 1);
    chk("to_data_hold", {8'd0, o_rsp_data}, 0);
    late_dly = 0; done_en = 1'b1;

    // Done coincides with the timeout cycle.
    done_dly = 255; exp_lat = 255; rx_val = 24'hC0FFEE;
    set_word(1, 24'h777777);
    txq.push_back(24'h777777);
    push_exp(3'b010, 24'hC0FFEE, 1'b0);
    @(posedge i_clk); #1 i_req = 3'b010;
    wait_ack(400);
    @(posedge i_clk); #1 i_req = '0;
    repeat (15) @(negedge i_clk);

    // Asynchronous reset in BUSY, then 0 and 2 contend.
    done_dly = 24; exp_lat = 24; rx_val = 24'h0D0D0D;
    set_word(0, 24'h111AAA);
    txq.push_back(24'h111AAA);
    @(posedge i_clk); #1 i_req = 3'b001;
    repeat (10) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_ack",      {29'd0, o_ack}, 0);
    chk("arst_tx_vld",   {31'd0, o_tx_vld}, 0);
    chk("arst_busy",     {31'd0, o_busy}, 0);
    chk("arst_tx_data",  {8'd0, o_tx_data}, 0);
    chk("arst_rsp_data", {8'd0, o_rsp_data}, 0);
    chk("arst_rsp_err",  {31'd0, o_rsp_err}, 0);
    i_req = '0;
    set_word(0, 24'hAAAAAA); set_word(2, 24'hBBBBBB);
    txq.push_back(24'hAAAAAA);
    txq.push_back(24'hBBBBBB);
    push_exp(3'b001, 24'h0D0D0D, 1'b0);
    push_exp(3'b100, 24'h0D0D0D, 1'b0);
    @(posedge i_clk);
    @(negedge i_clk);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    i_req   = 3'b101;
    wait_ack(100);
    @(posedge i_clk); #1 i_req = 3'b100;
    wait_ack(100);
    @(posedge i_clk); #1 i_req = '0;
    repeat (5) @(negedge i_clk);

    chk("expq_empty", expq.size(), 0);
    chk("txq_empty", txq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
